// File: rtl/drca_issuer_pkg.sv
// drca_issuer_pkg: shared FSM state encoding and wait-budget derivation for the DRCA issuer
package drca_issuer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Worst-case wait cycles: one launch cycle plus enough cycles for a full-width carry chain
    function automatic int calc_w_max(input int n, input int chain_bits);
        return 1 + (n + chain_bits - 1) / chain_bits;
    endfunction

endpackage

// File: rtl/drca_issuer_prop_run_len.sv
// prop_run_len: longest run of consecutive ones in a propagate vector (combinational)
//   p       in  N    propagate vector from the DRCA
//   run_len out RW   length of the longest run of ones, 0..N
module prop_run_len #(
    parameter int N = 8,
    localparam int RW = $clog2(N + 1)
) (
    input  logic [N-1:0]  p,
    output logic [RW-1:0] run_len
);

    logic [RW-1:0] run;

    always_comb begin
        run     = '0;
        run_len = '0;
        for (int i = 0; i < N; i++) begin
            run     = p[i] ? run + RW'(1) : '0;
            run_len = (run > run_len) ? run : run_len;
        end
    end

endmodule

// File: rtl/drca_issuer.sv
// drca_issuer: holds operands on a DRCA, waits only as long as the longest carry chain needs, returns S/Cout
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       operand request handshake; in_a, in_b, in_cin operands
//   out_valid/out_ready     result handshake; out_sum, out_cout result, out_cycles wait cycles used
//   drca_a/b/cin            registered operands driven to the DRCA; drca_enable DRCA enable
//   drca_s/cout/p           DRCA sum, carry out and propagate vector
module drca_issuer
    import drca_issuer_pkg::*;
#(
    parameter int N = 8,
    parameter int CHAIN_BITS = 4,
    localparam int W_MAX = calc_w_max(N, CHAIN_BITS),
    localparam int CW = $clog2(W_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    input  logic          in_cin,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_sum,
    output logic          out_cout,
    output logic [CW-1:0] out_cycles,
    output logic [N-1:0]  drca_a,
    output logic [N-1:0]  drca_b,
    output logic          drca_cin,
    output logic          drca_enable,
    input  logic [N-1:0]  drca_s,
    input  logic          drca_cout,
    input  logic [N-1:0]  drca_p
);

    localparam int RW = $clog2(N + 1);

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [RW-1:0] run_len;
    logic [CW-1:0] w;
    logic          accept;
    logic          capture;

    prop_run_len #(.N(N)) u_run (
        .p       (drca_p),
        .run_len (run_len)
    );

    // Ceiling is evaluated at integer width, so no intermediate can wrap before narrowing
    assign w = CW'(1 + (int'(run_len) + CHAIN_BITS - 1) / CHAIN_BITS);

    always_comb begin
        in_ready    = state == IDLE;
        out_valid   = state == HOLD;
        drca_enable = state == LAUNCH || state == WAIT;
        accept      = in_valid && in_ready;
        capture     = (state == LAUNCH && w == CW'(1)) || (state == WAIT && cnt == CW'(1));
        state_nx    = accept                  ? LAUNCH :
                      state == LAUNCH         ? (capture ? HOLD : WAIT) :
                      capture                 ? HOLD :
                      (out_valid && out_ready) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            out_sum    <= '0;
            out_cout   <= 1'b0;
            out_cycles <= '0;
            drca_a     <= '0;
            drca_b     <= '0;
            drca_cin   <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                drca_a   <= in_a;
                drca_b   <= in_b;
                drca_cin <= in_cin;
            end
            if (state == LAUNCH) begin
                cnt        <= w - CW'(1);
                out_cycles <= w;
            end else if (state == WAIT) begin
                cnt <= cnt - CW'(1);
            end
            if (capture) begin
                out_sum  <= drca_s;
                out_cout <= drca_cout;
            end
        end
    end

endmodule

// File: tb/tb_drca_issuer.sv
// tb_drca_issuer: scoreboard bench for drca_issuer with a behavioural DRCA
module tb_drca_issuer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [7:0] in_a, in_b;
    logic       in_cin;
    logic       out_valid, out_ready;
    logic [7:0] out_sum;
    logic       out_cout;
    logic [1:0] out_cycles;
    logic [7:0] drca_a, drca_b, drca_s, drca_p;
    logic       drca_cin, drca_enable, drca_cout;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic [1:0] cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;

    drca_issuer #(.N(8), .CHAIN_BITS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_cin      (in_cin),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_cout    (out_cout),
        .out_cycles  (out_cycles),
        .drca_a      (drca_a),
        .drca_b      (drca_b),
        .drca_cin    (drca_cin),
        .drca_enable (drca_enable),
        .drca_s      (drca_s),
        .drca_cout   (drca_cout),
        .drca_p      (drca_p)
    );

    assign {drca_cout, drca_s} = 9'(drca_a) + 9'(drca_b) + 9'(drca_cin);
    assign drca_p = drca_a ^ drca_b;

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int ref_w(input logic [7:0] p);
        int r = 0;
        int best = 0;
        for (int i = 0; i < 8; i++) begin
            r = p[i] ? r + 1 : 0;
            best = (r > best) ? r : best;
        end
        return 1 + (best + 3) / 4;
    endfunction

    // Scoreboard monitor: one comparison per completed result handshake
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'(out_sum), 32'hFFFF_FFFF);
            end else begin
                chk("sum", 32'(out_sum), 32'(sb[0].sum));
                chk("cout", 32'(out_cout), 32'(sb[0].cout));
                chk("cycles", 32'(out_cycles), 32'(sb[0].cyc));
                void'(sb.pop_front());
            end
        end
    end

    // Operands must not move while the DRCA is enabled
    logic [16:0] prev_ops;
    logic        prev_en;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en <= 1'b0;
        end else begin
            if (prev_en && drca_enable) chk("ops_stable", 32'({drca_a, drca_b, drca_cin}), 32'(prev_ops));
            prev_ops <= {drca_a, drca_b, drca_cin};
            prev_en  <= drca_enable;
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c, input int w, output bit ok);
        exp_t e;
        logic [8:0] full;
        in_a = a;
        in_b = b;
        in_cin = c;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            full = 9'(a) + 9'(b) + 9'(c);
            e.sum = full[7:0];
            e.cout = full[8];
            e.cyc = 2'(w);
            sb.push_back(e);
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c, input int w);
        int e0;
        bit ok;
        bit seen;
        e0 = edge_cnt;
        send(a, b, c, w, ok);
        if (!ok) return;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) begin
            chk("result_timeout", 32'd0, 32'd1);
            return;
        end
        chk("latency", 32'(edge_cnt - e0), 32'(1 + w));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_cin = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outs", 32'({out_sum, out_cout, out_cycles}), 32'd0);
        chk("rst_drca", 32'({drca_a, drca_b, drca_cin, drca_enable}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op(8'h00, 8'h00, 1'b0, 1);
        chk("t4_sum", 32'(out_sum), 32'h00);
        chk("t4_cycles", 32'(out_cycles), 32'd1);
        @(posedge clk);
        #1;

        run_op(8'hFF, 8'h00, 1'b1, 3);
        chk("t3_sum", 32'({out_cout, out_sum}), 32'h100);
        chk("t3_cycles", 32'(out_cycles), 32'd3);
        @(posedge clk);
        #1;

        run_op(8'h0F, 8'h01, 1'b0, 2);
        chk("t2_sum", 32'({out_cout, out_sum}), 32'h010);
        chk("t2_cycles", 32'(out_cycles), 32'd2);
        @(posedge clk);
        #1;

        send(8'hFF, 8'h00, 1'b1, 3, ok);
        @(posedge clk);
        #1;
        chk("abort_pre_enable", 32'(drca_enable), 32'd1);
        chk("abort_pre_sum", 32'(out_sum), 32'h10);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_outs", 32'({out_sum, out_cout, out_cycles}), 32'd0);
        chk("abort_drca", 32'({drca_a, drca_b, drca_cin, drca_enable}), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op(8'h0F, 8'h01, 1'b0, 2);
        chk("post_abort_sum", 32'(out_sum), 32'h10);
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        run_op(8'h3C, 8'h0F, 1'b0, 2);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_sum", 32'(out_sum), 32'h4B);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_enable", 32'(drca_enable), 32'd0);
            chk("bp_ignore_in", 32'(drca_a), 32'h3C);
            if (i == 4) begin
                in_a = 8'hAA;
                in_valid = 1'b1;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_idle", 32'(in_ready), 32'd1);

        for (int n = 0; n < 200; n++) begin
            logic [7:0] a, b;
            logic c;
            a = 8'($urandom);
            b = 8'($urandom);
            c = 1'($urandom);
            run_op(a, b, c, ref_w(a ^ b));
            @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
